// File: rtl/dm_pkg.sv
// Shared data-memory definitions: access-type encodings, lane-mask width and
// the store lane decode. Imported by the responder, the load extender and the
// core's bypass logic so every user agrees on the DMType encoding.
package dm_pkg;

  // One write-enable bit per byte lane of a 32-bit word.
  localparam int LANE_W = 4;

  // Access size and signedness as driven on the DM port. Codes 5..7 are unused
  // and treated as invalid accesses.
  typedef enum logic [2:0] {
    dm_word              = 3'b000,
    dm_halfword          = 3'b001,
    dm_halfword_unsigned = 3'b010,
    dm_byte              = 3'b011,
    dm_byte_unsigned     = 3'b100
  } dm_type_e;

  // True for the five defined access types.
  function automatic logic dm_type_valid(input logic [2:0] dm_type);
    return (dm_type <= 3'd4);
  endfunction

  // True for either halfword flavour (store size is the same for both).
  function automatic logic dm_is_half(input logic [2:0] dm_type);
    return (dm_type == dm_halfword) || (dm_type == dm_halfword_unsigned);
  endfunction

  // True for either byte flavour.
  function automatic logic dm_is_byte(input logic [2:0] dm_type);
    return (dm_type == dm_byte) || (dm_type == dm_byte_unsigned);
  endfunction

  // Byte lanes touched by a store of the given type at the given byte offset.
  // Halfwords align to byte_off[1]; words ignore the offset entirely.
  function automatic logic [LANE_W-1:0] dm_lane_mask(input logic [2:0] dm_type,
                                                     input logic [1:0] byte_off);
    logic [LANE_W-1:0] mask;
    mask = '0;
    if (dm_type == dm_word) begin
      mask = '1;
    end else if (dm_is_half(dm_type)) begin
      mask = byte_off[1] ? 4'b1100 : 4'b0011;
    end else if (dm_is_byte(dm_type)) begin
      mask = 4'b0001 << byte_off;
    end
    return mask;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane extract and sign/zero extension. Purely combinational so it can sit
// on the registered read path of dm_responder and also in the core's bypass
// network. Invalid access types produce zero.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  dm_type,
  output logic [31:0] data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Pick the addressed halfword and byte out of the word.
  always_comb begin
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
    case (byte_off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  // Extend the selected lane according to the access type.
  always_comb begin
    // NOTE: assigning a default before the case means every path drives data,
    // so no latch can be inferred even if an item is later removed.
    data = '0;
    case (dm_type)
      dm_word:              data = word;
      dm_halfword:          data = {{16{half_sel[15]}}, half_sel};
      dm_halfword_unsigned: data = {16'h0000, half_sel};
      dm_byte:              data = {{24{byte_sel[7]}}, byte_sel};
      dm_byte_unsigned:     data = {24'h000000, byte_sel};
      default:              data = '0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the core's DM port. Accepts one load or store per
// cycle against a word-organised RAM of 2^ADDR_WIDTH words, writes byte lanes
// on stores, and returns extended load data one cycle later with rvalid.
// Optional build macro DM_MISALIGN_CHECK_EN: reject misaligned half/word
// accesses with acc_err instead of silently truncating the low address bits.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  DMType,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        acc_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_off;
  logic                  addr_unused;
  logic                  misaligned;
  logic                  reject;
  logic                  wr_en;
  logic                  rd_req;
  logic [LANE_W-1:0]     wmask;
  logic [31:0]           wdata_lanes;
  logic [31:0]           rd_word;
  logic [31:0]           ext_data;

  // Addresses wrap modulo capacity: bits above the word index are dropped.
  assign word_idx    = addr[ADDR_WIDTH+1:2];
  assign byte_off    = addr[1:0];
  assign addr_unused = ^addr[31:ADDR_WIDTH+2];

`ifdef DM_MISALIGN_CHECK_EN
  // Flag halfwords on odd bytes and words off a 4-byte boundary.
  always_comb begin
    misaligned = 1'b0;
    if (DMType == dm_word) begin
      misaligned = |byte_off;
    end else if (dm_is_half(DMType)) begin
      misaligned = byte_off[0];
    end
  end
`else
  // Low address bits are simply truncated, so nothing is ever misaligned.
  assign misaligned = 1'b0;
`endif

  assign reject = !dm_type_valid(DMType) || misaligned;
  assign rd_req = req_valid && !mem_w;
  assign wr_en  = req_valid && mem_w && !reject && !reset;
  assign wmask  = dm_lane_mask(DMType, byte_off);

  // Replicate right-aligned store data across the lanes so each enabled lane
  // simply takes its own byte position.
  always_comb begin
    wdata_lanes = wdata;
    if (dm_is_half(DMType)) begin
      wdata_lanes = {2{wdata[15:0]}};
    end else if (dm_is_byte(DMType)) begin
      wdata_lanes = {4{wdata[7:0]}};
    end
  end

  // Byte-lane masked write into the word array.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch on purpose; contents survive reset
    // and a reset loop over every word would not map onto a RAM macro.
    if (wr_en) begin
      for (int l = 0; l < LANE_W; l++) begin
        if (wmask[l]) begin
          mem[word_idx][8*l +: 8] <= wdata_lanes[8*l +: 8];
        end
      end
    end
  end

  // Read the addressed word; a store on the previous edge is already visible.
  assign rd_word = mem[word_idx];

  dm_load_ext u_load_ext (
    .word     (rd_word),
    .byte_off (byte_off),
    .dm_type  (DMType),
    .data     (ext_data)
  );

  // Response registers: one-cycle rvalid/acc_err pulses, rdata held between loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata   <= '0;
      rvalid  <= 1'b0;
      acc_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, independent of statement order.
      rvalid  <= rd_req;
      acc_err <= req_valid && reject;
      if (rd_req) begin
        rdata <= reject ? 32'h0000_0000 : ext_data;
      end
    end
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder on the far end of the core's DM port. It accepts one load or store per cycle (`mem_w`, byte address, store data, `DMType`), performs byte/halfword/word lane selection on stores and sign/zero extension on loads, and returns load data one cycle later with a valid strobe. It sits between the pipelined core's MEM stage and the on-chip word-organised data RAM, replacing the combinational DM model.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; capacity is 2^ADDR_WIDTH 32-bit words (default 4 KiB).
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  a request is present this cycle.
- `mem_w`  in  1  1 = store, 0 = load; sampled only with `req_valid`.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `DMType`  in  3  access size and signedness (encodings under Structure).
- `rdata`  out  32  extended load result.
- `rvalid`  out  1  `rdata` valid this cycle; one-cycle pulse per load.
- `acc_err`  out  1  pulse alongside the response slot of a rejected access.

## Operation
- Word index is `addr[ADDR_WIDTH+1:2]`. Bits above it are ignored, so addresses wrap modulo capacity.
- Store with `req_valid & mem_w`, at the edge:
  - word: all four lanes written.
  - half: lanes {1,0} when `addr[1]`=0, lanes {3,2} when `addr[1]`=1, from `wdata[15:0]`.
  - byte: lane `addr[1:0]` written from `wdata[7:0]`.
  - Unwritten lanes are preserved.
  - Stores never raise `rvalid`.
- Load with `req_valid & ~mem_w`, at the edge:
  - The addressed word is read.
  - The lane is extracted and extended: sign-extended for h/b, zero-extended for hu/bu.
  - The result is registered into `rdata` and `rvalid`=1 for exactly the next cycle.
- `DMType` values 5–7 are invalid:
  - no write;
  - loads return `rdata`=0 with `rvalid`=1;
  - `acc_err`=1 in the response slot, stores included.
- Memory is not written while `reset` is high.
- Reset:
  - `rdata`=0, `rvalid`=0, `acc_err`=0 immediately on assertion.
  - Memory contents are unaffected.
  - A load in flight when reset asserts is discarded; no `rvalid`.
- `rdata` holds its last value while `rvalid`=0.

## Timing
- Load latency: request at edge N, `rdata`/`rvalid` valid in cycle N+1.
- Throughput: one request per cycle. Back-to-back loads give back-to-back `rvalid`.
- Read-after-write: a load in the cycle after a store to the same word returns the updated data.
- `acc_err` timing: asserted in cycle N+1 for a rejected request at edge N. Deasserted otherwise.

## Configuration
- `DM_MISALIGN_CHECK_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is rejected.
  - Rejected store: no write.
  - Rejected load: `rdata`=0, `rvalid`=1.
  - `acc_err`=1 in the response slot.
- Not defined:
  - Low address bits are truncated: half aligns to `addr[1]`; word ignores `addr[1:0]`.
  - `acc_err` is driven only by invalid `DMType`.

## Structure
- Shared package `dm_pkg` holds the `DMType` constants: `dm_word`=3'b000, `dm_halfword`=3'b001, `dm_halfword_unsigned`=3'b010, `dm_byte`=3'b011, `dm_byte_unsigned`=3'b100.
- The same package also holds the lane-mask width.
- One sub-module, `dm_load_ext`: combinational lane extract plus sign/zero extension. It is instantiated on the read path and reused by the core's bypass logic.
- Memory array, write-lane decode and response registers live in `dm_responder`.

## Test plan
- Word store/load: SW 0x12345678 @0x10, then LW @0x10 → `rdata`=0x12345678 with `rvalid` one cycle after the LW; no `rvalid` after the SW.
- Byte lanes: after the above, SB 0x000000AB @0x11, then:
  - LW @0x10 → 0x1234AB78.
  - LB @0x11 → 0xFFFFFFAB.
  - LBU @0x11 → 0x000000AB.
- Half lanes: SH 0x8001 @0x12, then:
  - LW @0x10 → 0x8001AB78.
  - LH @0x12 → 0xFFFF8001.
  - LHU @0x12 → 0x00008001.
- Misalign and invalid type:
  - With macro: LW @0x13 → `rvalid`=1, `rdata`=0, `acc_err`=1; SH @0x11 → `acc_err`=1, memory unchanged.
  - Without macro: LW @0x13 → word @0x10.
  - `DMType`=3'b111 store → no write, `acc_err`=1.
- Reset: assert `reset` in the cycle after a load request → `rvalid`, `rdata`, `acc_err` go to 0 without waiting for a clock edge. A store presented while reset is high is not written (a later LW returns the old value).
- Wrap: with `ADDR_WIDTH`=10, SW 0xDEADBEEF @0x1000, then LW @0x0 → 0xDEADBEEF. Back-to-back loads @0x0, @0x10 → consecutive `rvalid` cycles with the correct data.
